mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multi-cycle control unit for the MIPS-subset CPU. It sequences the shared ALU and the rest of the datapath through IF/ID/EX/MEM/WB, driving ALUSrc/ALUop into the ALU and consuming its zero/overflow flags. It also produces all PC, IR, memory and register-file enables. It replaces the single-cycle combinational decoder when the datapath is time-shared across cycles.

Parameters:
HALT_OP, 6'b111111, opcode that parks the FSM in HALT
OVF_TRAP, 1, 1 = suppress register write-back on signed overflow

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
OpCode  in  6  IR[31:26], valid from the ID cycle onward
func  in  6  IR[5:0], valid from the ID cycle onward
zero  in  1  ALU zero flag, combinational in EX
overflow  in  1  ALU signed-overflow flag, combinational in EX
PCWrite  out  1  PC load enable
PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target
IorD  out  1  memory address select: 0 = PC, 1 = ALU result
IRWrite  out  1  instruction register load
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
RegWrite  out  1  register-file write enable
RegDst  out  1  1 = rd, 0 = rt
MemtoReg  out  1  1 = memory data, 0 = ALU result
ALUSrc  out  1  1 = immediate, 0 = rt
ALUop  out  2  00 = add, 01 = sub, 10 = R-type by func, 11 = I-type by OpCode
ovf_exc  out  1  one-cycle pulse when write-back is suppressed
halted  out  1  high while in HALT
state  out  3  current state, for debug

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to IF on the next clock.
- Reset (reset==0 at a clock edge): state=IF, op_q=0, func_q=0, ovf_q=0.
- While reset is low, all outputs are forced to 0 combinationally, including halted. state reads 0.
- All other outputs are Moore-style, decoded from state, op_q and func_q. The only exception is the branch PCWrite in EX, which also uses zero.
- op_q and func_q capture OpCode and func on the ID->EX transition.
- Supported opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, ori=001101, j=000010, HALT_OP.
- Transitions:
  - IF -> ID unconditionally.
  - ID -> HALT if OpCode==HALT_OP.
  - ID -> IF if OpCode is unsupported (executed as a NOP).
  - ID -> EX otherwise.
  - EX -> MEM for lw/sw.
  - EX -> IF for beq/bne/j.
  - EX -> WB for R/addi/ori.
  - MEM -> WB for lw; MEM -> IF for sw.
  - WB -> IF.
  - HALT holds until reset.
- Cycle counts: lw 5; R/addi/ori/sw 4; beq/bne/j 3; unsupported opcode 2.
- IF outputs: MemRead=1, IorD=0, IRWrite=1, PCWrite=1, PCSrc=00.
- ID outputs: all enables 0.
- EX outputs:
  - ALUop: R=10, lw/sw=00, beq/bne=01, addi/ori=11.
  - ALUSrc=1 for lw/sw/addi/ori; 0 otherwise.
  - beq: PCWrite = zero. bne: PCWrite = ~zero. Branches use PCSrc=01.
  - j: PCWrite=1, PCSrc=10.
  - ALUop and ALUSrc are held through MEM and WB so the ALU result stays stable.
- Overflow latch: ovf_q <= overflow at the EX clock edge when op_q is addi, or R with func add(100000) or sub(100010). Otherwise ovf_q <= 0.
- MEM outputs: IorD=1. lw: MemRead=1. sw: MemWrite=1.
- WB outputs:
  - RegDst=1 for R; 0 otherwise.
  - MemtoReg=1 for lw.
  - RegWrite=1, except RegWrite=0 and ovf_exc=1 when OVF_TRAP=1 and ovf_q=1.
- Non-WB states: RegWrite=0, ovf_exc=0.
- Unlisted outputs are 0 in every state.
- MemRead and MemWrite are never both high; IRWrite and MemWrite are never both high.
- HALT: all enables 0, halted=1, state=5.
- Reset mid-instruction: the next state is IF and no partial write occurs in the reset cycle.

Test Plan:
- Reset low 2 cycles, then release -> all outputs 0 during reset; first cycle after release shows state=0, IRWrite=1, PCWrite=1, MemRead=1.
- add (OpCode=0, func=100000), overflow=0 -> states 0,1,2,4,0; EX ALUop=10, ALUSrc=0; WB RegWrite=1, RegDst=1.
- lw -> states 0,1,2,3,4; EX ALUop=00, ALUSrc=1; MEM MemRead=1, IorD=1; WB MemtoReg=1, RegWrite=1, RegDst=0.
- beq twice, zero=1 then zero=0 -> EX PCWrite=1/PCSrc=01 then PCWrite=0; ALUop=01; each returns to IF after 3 cycles. Repeat for bne with PCWrite inverted.
- addi with overflow=1 in EX, OVF_TRAP=1 -> WB RegWrite=0, ovf_exc=1 for exactly 1 cycle. Same with OVF_TRAP=0 -> RegWrite=1, ovf_exc=0.
- OpCode=111111 -> halted=1 and state=5 held 10+ cycles with zero enables. Unsupported OpCode=010000 -> ID->IF, no writes. Reset asserted in MEM of sw -> MemWrite=0, then IF.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit.
// Sequences IF/ID/EX/MEM/WB over a time-shared datapath.
module mc_ctrl_fsm #(
    parameter logic [5:0] HALT_OP  = 6'b111111,
    parameter bit         OVF_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       overflow,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic [1:0] ALUop,
    output logic       ovf_exc,
    output logic       halted,
    output logic [2:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic [5:0] func_q;
    logic       ovf_q;

    logic q_r, q_lw, q_sw, q_beq, q_bne, q_addi, q_ori, q_j;
    logic in_halt, in_sup, ovf_chk, trap_wb;

    assign q_r    = (op_q == OP_R);
    assign q_lw   = (op_q == OP_LW);
    assign q_sw   = (op_q == OP_SW);
    assign q_beq  = (op_q == OP_BEQ);
    assign q_bne  = (op_q == OP_BNE);
    assign q_addi = (op_q == OP_ADDI);
    assign q_ori  = (op_q == OP_ORI);
    assign q_j    = (op_q == OP_J);

    assign in_halt = (OpCode == HALT_OP);
    assign in_sup  = OpCode inside {OP_R, OP_LW, OP_SW, OP_BEQ,
                                    OP_BNE, OP_ADDI, OP_ORI, OP_J};

    // Only signed add forms can raise a trappable overflow.
    assign ovf_chk = q_addi
                   | (q_r & ((func_q == F_ADD) | (func_q == F_SUB)));
    assign trap_wb = OVF_TRAP && ovf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IF;
            op_q    <= '0;
            func_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID && state_d == S_EX) begin
                op_q   <= OpCode;
                func_q <= func;
            end
            if (state_q == S_EX) begin
                ovf_q <= ovf_chk & overflow;
            end
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:   state_d = S_ID;
            S_ID: begin
                if (in_halt)     state_d = S_HALT;
                else if (in_sup) state_d = S_EX;
                else             state_d = S_IF;
            end
            S_EX: begin
                if (q_lw | q_sw)                state_d = S_MEM;
                else if (q_r | q_addi | q_ori)  state_d = S_WB;
                else                            state_d = S_IF;
            end
            S_MEM:  state_d = q_lw ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        PCWrite  = 1'b0;
        PCSrc    = 2'b00;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        ALUop    = 2'b00;
        ovf_exc  = 1'b0;
        halted   = 1'b0;

        // ALU controls stay put through MEM/WB so the result is stable.
        if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
            unique case (1'b1)
                q_r:           ALUop = 2'b10;
                q_lw | q_sw:   ALUop = 2'b00;
                q_beq | q_bne: ALUop = 2'b01;
                q_addi | q_ori: ALUop = 2'b11;
                default:       ALUop = 2'b00;
            endcase
            ALUSrc = q_lw | q_sw | q_addi | q_ori;
        end

        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            S_EX: begin
                if (q_beq | q_bne) begin
                    PCSrc   = 2'b01;
                    PCWrite = q_beq ? zero : ~zero;
                end else if (q_j) begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                end
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = q_lw;
                MemWrite = q_sw;
            end
            S_WB: begin
                RegDst   = q_r;
                MemtoReg = q_lw;
                RegWrite = ~trap_wb;
                ovf_exc  = trap_wb;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase

        if (!reset) begin
            PCWrite  = 1'b0;
            PCSrc    = 2'b00;
            IorD     = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            ALUSrc   = 1'b0;
            ALUop    = 2'b00;
            ovf_exc  = 1'b0;
            halted   = 1'b0;
        end
    end

    assign state = reset ? state_q : 3'd0;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm against an instruction-level model.
// Runs trapping and non-trapping instances side by side.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode;
    logic [5:0] func;
    logic       zero;
    logic       overflow;

    logic       PCWrite  [2];
    logic [1:0] PCSrc    [2];
    logic       IorD     [2];
    logic       IRWrite  [2];
    logic       MemRead  [2];
    logic       MemWrite [2];
    logic       RegWrite [2];
    logic       RegDst   [2];
    logic       MemtoReg [2];
    logic       ALUSrc   [2];
    logic [1:0] ALUop    [2];
    logic       ovf_exc  [2];
    logic       halted   [2];
    logic [2:0] state    [2];
    logic [17:0] obs     [2];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_ctrl_fsm #(.HALT_OP(6'b111111), .OVF_TRAP(g == 1)) u_dut (
            .clk(clk), .reset(reset), .OpCode(OpCode), .func(func),
            .zero(zero), .overflow(overflow),
            .PCWrite(PCWrite[g]), .PCSrc(PCSrc[g]), .IorD(IorD[g]),
            .IRWrite(IRWrite[g]), .MemRead(MemRead[g]),
            .MemWrite(MemWrite[g]), .RegWrite(RegWrite[g]),
            .RegDst(RegDst[g]), .MemtoReg(MemtoReg[g]),
            .ALUSrc(ALUSrc[g]), .ALUop(ALUop[g]), .ovf_exc(ovf_exc[g]),
            .halted(halted[g]), .state(state[g])
        );
        assign obs[g] = {PCWrite[g], PCSrc[g], IorD[g], IRWrite[g],
                         MemRead[g], MemWrite[g], RegWrite[g], RegDst[g],
                         MemtoReg[g], ALUSrc[g], ALUop[g], ovf_exc[g],
                         halted[g], state[g]};
    end

    task automatic check(input string tag, input logic [17:0] got,
                         input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit supported(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 ||
               op == 6'h05 || op == 6'h08 || op == 6'h0d || op == 6'h02;
    endfunction

    // Phase codes: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB, 5 HALT.
    function automatic logic [17:0] expect_out(input int ph,
        input logic [5:0] op, input logic [5:0] fn, input logic z,
        input logic ovf, input bit trap);
        logic pcw, iord, irw, mrd, mwr, rw, rdst, m2r, asrc, oexc, hlt;
        logic [1:0] pcsrc, aop;
        bit r, lw, sw, beq, bne, addi, ori, j, trapped;
        r = op == 6'h00; lw = op == 6'h23; sw = op == 6'h2b;
        beq = op == 6'h04; bne = op == 6'h05; addi = op == 6'h08;
        ori = op == 6'h0d; j = op == 6'h02;
        {pcw, iord, irw, mrd, mwr, rw, rdst, m2r, asrc, oexc, hlt} = '0;
        pcsrc = 2'b00;
        aop = 2'b00;
        if (ph >= 2 && ph <= 4) begin
            if (r)               aop = 2'b10;
            else if (beq || bne) aop = 2'b01;
            else if (addi || ori) aop = 2'b11;
            asrc = lw || sw || addi || ori;
        end
        case (ph)
            0: begin mrd = 1; irw = 1; pcw = 1; end
            2: begin
                if (beq) begin pcw = z;  pcsrc = 2'b01; end
                if (bne) begin pcw = !z; pcsrc = 2'b01; end
                if (j)   begin pcw = 1;  pcsrc = 2'b10; end
            end
            3: begin iord = 1; mrd = lw; mwr = sw; end
            4: begin
                trapped = trap && ovf &&
                    (addi || (r && (fn == 6'h20 || fn == 6'h22)));
                rdst = r; m2r = lw; rw = !trapped; oexc = trapped;
            end
            5: hlt = 1;
            default: ;
        endcase
        return {pcw, pcsrc, iord, irw, mrd, mwr, rw, rdst, m2r, asrc,
                aop, oexc, hlt, 3'(ph)};
    endfunction

    // Caller is at a negedge; returns at the negedge after the last cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zsel, input int osel,
                             input int abort_at);
        int ph[$];
        logic ovf_ex;
        ph = {0, 1};
        if (op == 6'h3f) begin
            repeat (12) ph.push_back(5);
        end else if (supported(op)) begin
            ph.push_back(2);
            if (op == 6'h23) begin ph.push_back(3); ph.push_back(4); end
            else if (op == 6'h2b) ph.push_back(3);
            else if (op == 6'h00 || op == 6'h08 || op == 6'h0d)
                ph.push_back(4);
        end
        OpCode = op;
        func   = fn;
        ovf_ex = 1'b0;
        foreach (ph[i]) begin
            zero     = 1'($urandom());
            overflow = 1'($urandom());
            if (ph[i] == 2) begin
                if (zsel >= 0) zero = zsel[0];
                if (osel >= 0) overflow = osel[0];
                ovf_ex = overflow;
            end
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                for (int g = 0; g < 2; g++)
                    check($sformatf("abort_op%h_ph%0d_t%0d", op, ph[i], g),
                          obs[g], 18'h0);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            #1;
            for (int g = 0; g < 2; g++)
                check($sformatf("op%h_fn%h_ph%0d_t%0d", op, fn, ph[i], g),
                      obs[g], expect_out(ph[i], op, fn, zero, ovf_ex, g == 1));
            @(negedge clk);
        end
    endtask

    task automatic run_random(input int n);
        logic [5:0] ops [9];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h02, 6'h00};
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(9, 0) == 0) begin
                do op = 6'($urandom()); while (supported(op) || op == 6'h3f);
            end else begin
                op = ops[$urandom_range(8, 0)];
            end
            case ($urandom_range(3, 0))
                0: fn = 6'h20;
                1: fn = 6'h22;
                default: fn = 6'($urandom());
            endcase
            run_instr(op, fn, -1, -1, -1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; OpCode = '0; func = '0; zero = 1'b0; overflow = 1'b0;
        repeat (2) begin
            @(negedge clk);
            OpCode = 6'($urandom()); func = 6'($urandom());
            zero = 1'($urandom()); overflow = 1'($urandom());
            #1;
            for (int g = 0; g < 2; g++)
                check($sformatf("reset_t%0d", g), obs[g], 18'h0);
        end
        @(negedge clk);
        reset = 1'b1;

        run_instr(6'h00, 6'h20, -1, 0, -1);
        run_instr(6'h23, 6'h00, -1, -1, -1);
        run_instr(6'h04, 6'h00, 1, -1, -1);
        run_instr(6'h04, 6'h00, 0, -1, -1);
        run_instr(6'h05, 6'h00, 1, -1, -1);
        run_instr(6'h05, 6'h00, 0, -1, -1);
        run_instr(6'h08, 6'h00, -1, 1, -1);
        run_instr(6'h08, 6'h00, -1, 0, -1);
        run_instr(6'h00, 6'h22, -1, 1, -1);
        run_instr(6'h00, 6'h24, -1, 1, -1);
        run_instr(6'h0d, 6'h00, -1, 1, -1);
        run_instr(6'h02, 6'h00, -1, -1, -1);
        run_instr(6'h10, 6'h00, -1, -1, -1);
        run_instr(6'h2b, 6'h00, -1, -1, 3);
        run_instr(6'h2b, 6'h00, -1, -1, -1);

        run_random(300);

        run_instr(6'h3f, 6'h00, -1, -1, -1);
        reset = 1'b0;
        #1;
        for (int g = 0; g < 2; g++)
            check($sformatf("halt_reset_t%0d", g), obs[g], 18'h0);
        @(negedge clk);
        reset = 1'b1;
        run_random(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
